// File: rtl/flag_pkg.sv
// Shared definitions for the NZCV flag consumers and the status register.
package flag_pkg;

    // Bit positions inside the 4-bit flag vector {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ARM-style condition codes.
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/flag_cond_decode.sv
// Pure combinational condition-code decoder; reusable by predication logic.
module flag_cond_decode
    import flag_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Evaluate the condition code against the supplied flags.
    always_comb begin
        // NOTE: assign a default before the case so no path can infer a latch.
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = z || (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_eval.sv
// Condition-code evaluator: holds the NZCV flags and answers condition
// queries through a two-stage valid/ready pipeline with statistics counters.
module flag_cond_eval
    import flag_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic [3:0]       flag_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_taken,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       rsp_flags,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    logic [3:0]       flags_q, flags_d;
    logic             s1_v_q, s1_v_d;
    logic [3:0]       s1_cond_q, s1_cond_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [3:0]       s1_flags_q, s1_flags_d;
    logic             s2_v_q, s2_v_d;
    logic             s2_taken_q, s2_taken_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

    logic s2_adv, s1_adv, accept, consume, s1_taken;

    flag_cond_decode u_decode (
        .cond  (s1_cond_q),
        .flags (s1_flags_q),
        .taken (s1_taken)
    );

    // Handshake: S2 frees when empty or consumed; S1 moves when S2 frees.
    always_comb begin
        s2_adv    = !s2_v_q || rsp_ready;
        s1_adv    = s1_v_q && s2_adv;
        req_ready = !s1_v_q || s2_adv;
        accept    = req_valid && req_ready;
        consume   = s2_v_q && rsp_ready;
    end

    // Next-state for flag register, both pipeline stages and counters.
    always_comb begin
        // The new flag value doubles as the write-before-read snapshot.
        flags_d      = flag_we ? flag_in : flags_q;

        s1_v_d       = s1_v_q;
        s1_cond_d    = s1_cond_q;
        s1_tag_d     = s1_tag_q;
        s1_flags_d   = s1_flags_q;
        if (accept) begin
            s1_v_d     = 1'b1;
            s1_cond_d  = req_cond;
            s1_tag_d   = req_tag;
            s1_flags_d = flags_d;
        end else if (s1_adv) begin
            s1_v_d     = 1'b0;
        end

        s2_v_d       = s2_v_q;
        s2_taken_d   = s2_taken_q;
        s2_tag_d     = s2_tag_q;
        s2_flags_d   = s2_flags_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
        end
        if (s1_adv) begin
            s2_taken_d = s1_taken;
            s2_tag_d   = s1_tag_q;
            s2_flags_d = s1_flags_q;
        end

        taken_cnt_d  = taken_cnt_q;
        ntaken_cnt_d = ntaken_cnt_q;
        if (consume) begin
            if (s2_taken_q) begin
                if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
            end else begin
                if (ntaken_cnt_q != '1) ntaken_cnt_d = ntaken_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            flags_q      <= '0;
            s1_v_q       <= 1'b0;
            s1_cond_q    <= '0;
            s1_tag_q     <= '0;
            s1_flags_q   <= '0;
            s2_v_q       <= 1'b0;
            s2_taken_q   <= 1'b0;
            s2_tag_q     <= '0;
            s2_flags_q   <= '0;
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            s1_v_q       <= s1_v_d;
            s1_cond_q    <= s1_cond_d;
            s1_tag_q     <= s1_tag_d;
            s1_flags_q   <= s1_flags_d;
            s2_v_q       <= s2_v_d;
            s2_taken_q   <= s2_taken_d;
            s2_tag_q     <= s2_tag_d;
            s2_flags_q   <= s2_flags_d;
            taken_cnt_q  <= taken_cnt_d;
            ntaken_cnt_q <= ntaken_cnt_d;
        end
    end

    assign rsp_valid  = s2_v_q;
    assign rsp_taken  = s2_taken_q;
    assign rsp_tag    = s2_tag_q;
    assign rsp_flags  = s2_flags_q;
    assign taken_cnt  = taken_cnt_q;
    assign ntaken_cnt = ntaken_cnt_q;

endmodule

// File: tb/tb_flag_cond_eval.sv
// Self-checking bench for flag_cond_eval: directed sequences, a full
// code x flags sweep, backpressure, reset, and counter saturation.
module tb_flag_cond_eval;
    import flag_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cond;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_taken;
    logic [3:0]  rsp_tag;
    logic [3:0]  rsp_flags;
    logic [15:0] taken_cnt;
    logic [15:0] ntaken_cnt;

    // Second instance with narrow counters for the saturation test.
    logic        s_flag_we   = 1'b0;
    logic [3:0]  s_flag_in   = 4'd0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [3:0]  s_req_cond  = COND_AL;
    logic [3:0]  s_req_tag   = 4'd0;
    logic        s_rsp_valid;
    logic        s_rsp_ready = 1'b1;
    logic        s_rsp_taken;
    logic [3:0]  s_rsp_tag;
    logic [3:0]  s_rsp_flags;
    logic [3:0]  s_taken_cnt;
    logic [3:0]  s_ntaken_cnt;

    always #5 clk = ~clk;

    flag_cond_eval #(.TAG_W(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
        .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_taken(rsp_taken), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
        .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
    );

    flag_cond_eval #(.TAG_W(4), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flag_we(s_flag_we), .flag_in(s_flag_in),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_cond(s_req_cond),
        .req_tag(s_req_tag), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_taken(s_rsp_taken), .rsp_tag(s_rsp_tag), .rsp_flags(s_rsp_flags),
        .taken_cnt(s_taken_cnt), .ntaken_cnt(s_ntaken_cnt)
    );

    typedef struct {
        logic       taken;
        logic [3:0] tag;
        logic [3:0] flags;
    } exp_t;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       we;
        logic       exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vec[256];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   stalls = 0;
    int   consumed = 0;
    int   m_taken = 0;
    int   m_ntaken = 0;
    logic [3:0] fmodel = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: predicate chosen by cond[3:1], inverted by cond[0].
    function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, p;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: p = z;
            3'd1: p = c;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = c & ~z;
            3'd5: p = (n == v);
            3'd6: p = ~z & (n == v);
            default: p = 1'b1;
        endcase
        return p ^ cond[0];
    endfunction

    // Architectural flag model.
    always @(posedge clk) begin
        if (reset) fmodel <= 4'd0;
        else if (flag_we) fmodel <= flag_in;
    end

    // Scoreboard monitor: samples just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_taken  = 0;
            m_ntaken = 0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else if (rsp_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_taken", 32'(rsp_taken), 32'(e.taken));
                check("rsp_tag",   32'(rsp_tag),   32'(e.tag));
                check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                consumed++;
                if (e.taken) m_taken++;
                else m_ntaken++;
            end else begin
                check("hold_taken", 32'(rsp_taken), 32'(exp_q[0].taken));
                check("hold_tag",   32'(rsp_tag),   32'(exp_q[0].tag));
                check("hold_flags", 32'(rsp_flags), 32'(exp_q[0].flags));
            end
        end
    end

    // Drive one query (optionally with a same-cycle flag write) until accepted.
    task automatic send(input logic [3:0] cond, input logic [3:0] tag,
                        input logic we, input logic [3:0] fin);
        int   wait_cyc;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_cond  = cond;
        req_tag   = tag;
        flag_we   = we;
        flag_in   = fin;
        #1;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin
            stalls++;
            wait_cyc++;
            @(negedge clk);
            #1;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            flag_we   = 1'b0;
        end else begin
            e.flags = flag_we ? flag_in : fmodel;
            e.taken = cond_model(cond, e.flags);
            e.tag   = tag;
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic wflag(input logic [3:0] v);
        @(negedge clk);
        req_valid = 1'b0;
        flag_we   = 1'b1;
        flag_in   = v;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        flag_we   = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        flag_we   = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_total;
        int st0, c0;
        reset = 1'b1; flag_we = 1'b0; flag_in = 4'd0; req_valid = 1'b0;
        req_cond = 4'd0; req_tag = 4'd0; rsp_ready = 1'b1;

        // Build the sweep table: flag value outer, code inner; code 0 writes flags.
        exp_total = 0;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                vec[f*16+c].cond  = 4'(c);
                vec[f*16+c].flags = 4'(f);
                vec[f*16+c].we    = (c == 0);
                vec[f*16+c].exp   = cond_model(4'(c), 4'(f));
                exp_total += int'(vec[f*16+c].exp);
            end
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_taken", 32'(rsp_taken), 32'd0);
        check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        check("rst_ntaken_cnt", 32'(ntaken_cnt), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Basic query and latency: EQ with Z set.
        wflag(4'b0100);
        send(COND_EQ, 4'd3, 1'b0, 4'd0);
        idle();
        #1;
        check("lat_s1_only", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        check("eq_taken", 32'(rsp_taken), 32'd1);
        check("eq_tag",   32'(rsp_tag),   32'd3);
        check("eq_flags", 32'(rsp_flags), 32'b0100);
        send(COND_NE, 4'd4, 1'b0, 4'd0);
        idle();
        wait_empty();

        // Write-before-read bypass, then a later write must not disturb it.
        wflag(4'b1000);
        send(COND_GE, 4'd5, 1'b1, 4'b1001);
        wflag(4'b0000);
        idle();
        #1;
        check("byp_valid", 32'(rsp_valid), 32'd1);
        check("byp_taken", 32'(rsp_taken), 32'd1);
        check("byp_flags", 32'(rsp_flags), 32'b1001);
        wait_empty();

        // Backpressure: fill both stages, third query must stall.
        c0 = consumed;
        idle();
        rsp_ready = 1'b0;
        send(COND_CS, 4'd8, 1'b1, 4'b0010);
        send(COND_CC, 4'd9, 1'b0, 4'd0);
        @(negedge clk);
        req_valid = 1'b1; req_cond = COND_EQ; req_tag = 4'd10; flag_we = 1'b0;
        #1;
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("full_rsp_tag",   32'(rsp_tag),   32'd8);
        fork
            send(COND_EQ, 4'd10, 1'b0, 4'd0);
            begin
                repeat (3) @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        idle();
        wait_empty();
        check("bp_consumed", 32'(consumed - c0), 32'd3);
        check("bp_taken_cnt",  32'(taken_cnt),  32'(m_taken));
        check("bp_ntaken_cnt", 32'(ntaken_cnt), 32'(m_ntaken));

        // Reset while both stages are full.
        wflag(4'b1111);
        idle();
        rsp_ready = 1'b0;
        send(COND_AL, 4'd1, 1'b0, 4'd0);
        send(COND_AL, 4'd2, 1'b0, 4'd0);
        idle();
        #1;
        check("pre_rst_full", 32'(req_ready), 32'd0);
        do_reset();
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
        check("mid_rst_ntaken_cnt", 32'(ntaken_cnt), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_flags", 32'(rsp_flags), 32'd0);
        send(COND_EQ, 4'd7, 1'b0, 4'd0);
        idle();
        wait_empty();

        // Full sweep with rsp_ready high: one result per cycle.
        do_reset();
        st0 = stalls;
        c0  = consumed;
        for (int i = 0; i < 256; i++) begin
            send(vec[i].cond, 4'(i), vec[i].we, vec[i].flags);
        end
        idle();
        wait_empty();
        check("sweep_stalls",    32'(stalls - st0), 32'd0);
        check("sweep_consumed",  32'(consumed - c0), 32'd256);
        check("sweep_cnt_sum",   32'(taken_cnt) + 32'(ntaken_cnt), 32'd256);
        check("sweep_taken_cnt", 32'(taken_cnt), 32'(exp_total));

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_req_valid = 1'b1;
            s_req_cond  = COND_AL;
            #1;
            if (i == 0 || i == 19) check("sat_req_ready", 32'(s_req_ready), 32'd1);
        end
        @(negedge clk);
        s_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sat_taken_cnt",  32'(s_taken_cnt),  32'd15);
        check("sat_ntaken_cnt", 32'(s_ntaken_cnt), 32'd0);
        @(negedge clk);
        s_req_valid = 1'b1;
        s_req_cond  = COND_NV;
        @(negedge clk);
        s_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sat_taken_hold",  32'(s_taken_cnt),  32'd15);
        check("sat_ntaken_inc",  32'(s_ntaken_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
